// File: rtl/microcode_sequencer_pkg.sv
// Shared microcode types, sequencer states and the per-opcode microprogram ROM.
// Imported by the sequencer, its wait selector and the decoder interface.
package microcode_sequencer_pkg;

    localparam int OPCODE_W  = 8;
    localparam int MAX_STEPS = 16;
    localparam int STEP_W    = $clog2(MAX_STEPS);

    typedef enum logic [4:0] {
        ENDMICRO,
        PC_to_MAR,
        RAM_to_IR,
        INC_PC,
        RAM_to_MAR,
        RAM_to_A,
        A_to_RAM,
        ALU_ADD,
        WAIT_CYCLE,
        START_MT,
        WAIT_MT,
        START_UT,
        WAIT_UT,
        START_FT,
        WAIT_FT,
        START_DD,
        WAIT_DD,
        START_GPU,
        WAIT_GPU,
        HLT_CLK
    } Microcode_enum;

    typedef enum logic [1:0] {FETCH, EXEC, HALTED} seq_state_t;
    typedef enum logic [1:0] {F0, F1, F2} fetch_phase_t;

    localparam logic [7:0] OP_LAST = 8'h0A;

    function automatic logic opcode_valid(input logic [7:0] opcode);
        return opcode <= OP_LAST;
    endfunction

    function automatic logic is_wait(input Microcode_enum c);
        return c inside {WAIT_CYCLE, WAIT_MT, WAIT_UT, WAIT_FT, WAIT_DD, WAIT_GPU};
    endfunction

    function automatic Microcode_enum seq2(input logic [7:0] stp,
                                           input Microcode_enum a,
                                           input Microcode_enum b);
        if (stp == 8'd0) return a;
        if (stp == 8'd1) return b;
        return ENDMICRO;
    endfunction

    // Undefined opcodes fall to ENDMICRO at step 0, a one-cycle no-op.
    function automatic Microcode_enum micro_rom(input logic [7:0] opcode,
                                                input logic [7:0] stp);
        Microcode_enum c;
        c = ENDMICRO;
        case (opcode)
            8'h01:   c = seq2(stp, RAM_to_MAR, RAM_to_A);
            8'h02:   c = seq2(stp, START_MT, WAIT_MT);
            8'h03:   c = seq2(stp, START_UT, WAIT_UT);
            8'h04:   c = seq2(stp, START_FT, WAIT_FT);
            8'h05:   c = seq2(stp, START_DD, WAIT_DD);
            8'h06:   c = seq2(stp, START_GPU, WAIT_GPU);
            8'h07:   c = seq2(stp, ALU_ADD, HLT_CLK);
            8'h08:   c = seq2(stp, WAIT_CYCLE, A_to_RAM);
            8'h09:   c = ALU_ADD;
            8'h0A:   c = seq2(stp, RAM_to_MAR, A_to_RAM);
            default: c = ENDMICRO;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/microcode_sequencer_if.sv
// Sequencer-to-decoder bundle: microcode stream plus debug/status strobes.
// The sequencer drives it as master; the decoder listens as slave.
interface microcode_sequencer_if
    import microcode_sequencer_pkg::*;
#(
    parameter int STEP_W = microcode_sequencer_pkg::STEP_W
);
    Microcode_enum     current_microcode;
    seq_state_t        seq_state;
    logic [STEP_W-1:0] step;
    logic              instr_start;
    logic              illegal_op;

    modport master (
        output current_microcode, seq_state, step, instr_start, illegal_op
    );
    modport slave (
        input current_microcode, seq_state, step, instr_start, illegal_op
    );
endinterface

// File: rtl/microcode_sequencer_wait_select.sv
// Maps a WAIT_* microcode and the peripheral busy vector to a stall.
// busy bit order: {gpu, dd, ftu, us, ms}.
module microcode_wait_select
    import microcode_sequencer_pkg::*;
(
    input  Microcode_enum code,
    input  logic [4:0]    busy,
    output logic          stall
);
    always_comb begin
        stall = 1'b0;
        if (is_wait(code)) begin
            unique case (code)
                WAIT_MT:  stall = busy[0];
                WAIT_UT:  stall = busy[1];
                WAIT_FT:  stall = busy[2];
                WAIT_DD:  stall = busy[3];
                WAIT_GPU: stall = busy[4];
                default:  stall = 1'b0;
            endcase
        end
    end
endmodule

// File: rtl/microcode_sequencer.sv
// Fetch/execute microcode sequencer feeding the microcode decoder.
// Runs F0-F2 fetch, then the ROM microprogram with WAIT stalls and HALT parking.
module microcode_sequencer
    import microcode_sequencer_pkg::*;
#(
    parameter int OPCODE_W  = microcode_sequencer_pkg::OPCODE_W,
    parameter int MAX_STEPS = microcode_sequencer_pkg::MAX_STEPS,
    parameter int STEP_W    = $clog2(MAX_STEPS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                step_en,
    input  logic                resume,
    input  logic [OPCODE_W-1:0] ir_opcode,
    input  logic                ms_busy,
    input  logic                us_busy,
    input  logic                ftu_busy,
    input  logic                dd_busy,
    input  logic                gpu_busy,
    microcode_sequencer_if.master dec
);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);

    seq_state_t          state_q, state_d;
    fetch_phase_t        phase_q, phase_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic                first_q, first_d;
    logic                ill_q, ill_d;
    Microcode_enum       rom_code, code;
    logic                stall;

    assign rom_code = micro_rom(8'(opcode_q), 8'(step_q));

    microcode_wait_select u_wait (
        .code  (rom_code),
        .busy  ({gpu_busy, dd_busy, ftu_busy, us_busy, ms_busy}),
        .stall (stall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            phase_q  <= F0;
            step_q   <= '0;
            opcode_q <= '0;
            first_q  <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            step_q   <= step_d;
            opcode_q <= opcode_d;
            first_q  <= first_d;
            ill_q    <= ill_d;
        end
    end

    always_comb begin
        code = PC_to_MAR;
        unique case (state_q)
            FETCH: begin
                unique case (phase_q)
                    F1:      code = RAM_to_IR;
                    F2:      code = INC_PC;
                    default: code = PC_to_MAR;
                endcase
            end
            EXEC:    code = rom_code;
            HALTED:  code = HLT_CLK;
            default: code = PC_to_MAR;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        step_d   = step_q;
        opcode_d = opcode_q;
        first_d  = first_q;
        ill_d    = ill_q;
        // Everything, including pending pulses, freezes while step_en is low.
        if (step_en) begin
            first_d = 1'b0;
            ill_d   = 1'b0;
            unique case (state_q)
                FETCH: begin
                    unique case (phase_q)
                        F0: phase_d = F1;
                        F1: phase_d = F2;
                        F2: begin
                            state_d  = EXEC;
                            phase_d  = F0;
                            step_d   = '0;
                            opcode_d = ir_opcode;
                            first_d  = 1'b1;
                            ill_d    = !opcode_valid(8'(ir_opcode));
                        end
                        default: phase_d = F0;
                    endcase
                end
                EXEC: begin
                    if (rom_code == ENDMICRO) begin
                        state_d = FETCH;
                        step_d  = '0;
                    end else if (rom_code == HLT_CLK) begin
                        state_d = HALTED;
                        step_d  = '0;
                    end else if (stall) begin
                        step_d = step_q;
                    end else if (step_q == LAST_STEP) begin
                        state_d = FETCH;
                        step_d  = '0;
                        ill_d   = 1'b1;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
                HALTED: begin
                    if (resume) begin
                        state_d = FETCH;
                        phase_d = F0;
                    end
                end
                default: begin
                    state_d = FETCH;
                    phase_d = F0;
                    step_d  = '0;
                end
            endcase
        end
    end

    assign dec.current_microcode = code;
    assign dec.seq_state         = state_q;
    assign dec.step              = step_q;
    assign dec.instr_start       = step_en & first_q & (state_q == EXEC);
    assign dec.illegal_op        = step_en & ill_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Checks microcode_sequencer against a position-counter reference model,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_microcode_sequencer;
    import microcode_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       step_en = 1'b0;
    logic       resume = 1'b0;
    logic [7:0] ir_opcode = 8'h00;
    logic       ms_busy = 1'b0, us_busy = 1'b0, ftu_busy = 1'b0;
    logic       dd_busy = 1'b0, gpu_busy = 1'b0;

    int checks = 0;
    int errors = 0;

    microcode_sequencer_if #(.STEP_W(4)) dec ();

    microcode_sequencer #(
        .OPCODE_W  (8),
        .MAX_STEPS (16),
        .STEP_W    (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_en   (step_en),
        .resume    (resume),
        .ir_opcode (ir_opcode),
        .ms_busy   (ms_busy),
        .us_busy   (us_busy),
        .ftu_busy  (ftu_busy),
        .dd_busy   (dd_busy),
        .gpu_busy  (gpu_busy),
        .dec       (dec)
    );

    always #5 clk = ~clk;

    // Model: position 0..2 = fetch phases, 3+k = execute step k.
    bit m_halt;
    int m_pos;
    int m_op;
    bit m_first;
    bit m_ill;

    Microcode_enum cap_code[$];
    int            cap_step[$];
    seq_state_t    cap_st[$];
    bit            cap_start[$];
    bit            cap_ill[$];

    function automatic Microcode_enum ref_code(int op, int s);
        Microcode_enum p[$];
        case (op)
            1:  p = '{RAM_to_MAR, RAM_to_A, ENDMICRO};
            2:  p = '{START_MT, WAIT_MT, ENDMICRO};
            3:  p = '{START_UT, WAIT_UT, ENDMICRO};
            4:  p = '{START_FT, WAIT_FT, ENDMICRO};
            5:  p = '{START_DD, WAIT_DD, ENDMICRO};
            6:  p = '{START_GPU, WAIT_GPU, ENDMICRO};
            7:  p = '{ALU_ADD, HLT_CLK};
            8:  p = '{WAIT_CYCLE, A_to_RAM, ENDMICRO};
            9:  return ALU_ADD;
            10: p = '{RAM_to_MAR, A_to_RAM, ENDMICRO};
            default: p = '{ENDMICRO};
        endcase
        if (s < p.size()) return p[s];
        return ENDMICRO;
    endfunction

    function automatic bit busy_flag(Microcode_enum c);
        case (c)
            WAIT_MT:  return ms_busy;
            WAIT_UT:  return us_busy;
            WAIT_FT:  return ftu_busy;
            WAIT_DD:  return dd_busy;
            WAIT_GPU: return gpu_busy;
            default:  return 1'b0;
        endcase
    endfunction

    task automatic check1(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_halt = 0; m_pos = 0; m_op = 0; m_first = 0; m_ill = 0;
    endtask

    task automatic model_step();
        bit nf, ni;
        Microcode_enum c;
        nf = 0; ni = 0;
        if (!step_en) return;
        if (m_halt) begin
            if (resume) begin m_halt = 0; m_pos = 0; end
        end else if (m_pos < 2) begin
            m_pos++;
        end else if (m_pos == 2) begin
            m_op = int'(ir_opcode);
            m_pos = 3;
            nf = 1;
            ni = (ir_opcode > 8'h0A);
        end else begin
            c = ref_code(m_op, m_pos - 3);
            if (c == ENDMICRO) m_pos = 0;
            else if (c == HLT_CLK) begin m_halt = 1; m_pos = 0; end
            else if (busy_flag(c)) m_pos = m_pos;
            else if (m_pos - 3 == 15) begin m_pos = 0; ni = 1; end
            else m_pos++;
        end
        m_first = nf;
        m_ill = ni;
    endtask

    task automatic check_model();
        Microcode_enum ec;
        seq_state_t es;
        int est;
        bit estart, eill;
        if (m_halt) ec = HLT_CLK;
        else if (m_pos == 0) ec = PC_to_MAR;
        else if (m_pos == 1) ec = RAM_to_IR;
        else if (m_pos == 2) ec = INC_PC;
        else ec = ref_code(m_op, m_pos - 3);
        es = m_halt ? HALTED : (m_pos < 3 ? FETCH : EXEC);
        est = (!m_halt && m_pos >= 3) ? m_pos - 3 : 0;
        estart = step_en && !m_halt && m_pos == 3 && m_first;
        eill = step_en && m_ill;
        check1("code", int'(dec.current_microcode), int'(ec));
        check1("state", int'(dec.seq_state), int'(es));
        check1("step", int'(dec.step), est);
        check1("instr_start", int'(dec.instr_start), int'(estart));
        check1("illegal_op", int'(dec.illegal_op), int'(eill));
        cap_code.push_back(dec.current_microcode);
        cap_step.push_back(int'(dec.step));
        cap_st.push_back(dec.seq_state);
        cap_start.push_back(dec.instr_start);
        cap_ill.push_back(dec.illegal_op);
    endtask

    task automatic clear_cap();
        cap_code.delete(); cap_step.delete(); cap_st.delete();
        cap_start.delete(); cap_ill.delete();
    endtask

    task automatic tick();
        #1;
        check_model();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(string tag);
        check1({tag, "_code"}, int'(dec.current_microcode), int'(PC_to_MAR));
        check1({tag, "_state"}, int'(dec.seq_state), int'(FETCH));
        check1({tag, "_step"}, int'(dec.step), 0);
        check1({tag, "_start"}, int'(dec.instr_start), 0);
        check1({tag, "_ill"}, int'(dec.illegal_op), 0);
    endtask

    initial begin
        int n, m;
        Microcode_enum nop_exp[5];
        nop_exp = '{PC_to_MAR, RAM_to_IR, INC_PC, ENDMICRO, PC_to_MAR};

        #1 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        model_reset();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        step_en = 1'b1;

        // NOP instruction
        ir_opcode = 8'h00;
        clear_cap();
        repeat (5) tick();
        for (int i = 0; i < 5; i++) check1("nop_seq", int'(cap_code[i]), int'(nop_exp[i]));
        check1("nop_start_c4", int'(cap_start[3]), 1);

        // LDA: RAM_to_MAR, RAM_to_A, ENDMICRO
        ir_opcode = 8'h01;
        clear_cap();
        repeat (6) tick();
        check1("lda_s0", int'(cap_code[2]), int'(RAM_to_MAR));
        check1("lda_s1", int'(cap_code[3]), int'(RAM_to_A));
        check1("lda_s2", int'(cap_code[4]), int'(ENDMICRO));
        check1("lda_refetch", int'(cap_code[5]), int'(PC_to_MAR));

        // WAIT_MT with ms_busy high for 5 cycles after START_MT
        ir_opcode = 8'h02;
        clear_cap();
        repeat (3) tick();
        ms_busy = 1'b1;
        repeat (5) tick();
        ms_busy = 1'b0;
        repeat (3) tick();
        n = 0; m = 0;
        foreach (cap_code[i]) if (cap_code[i] == WAIT_MT) begin
            n++;
            if (cap_step[i] == 1) m++;
        end
        check1("wait_mt_cycles", n, 6);
        check1("wait_mt_step1", m, 6);

        // HLT, with resume held high across the HLT_CLK step
        ir_opcode = 8'h07;
        repeat (3) tick();
        resume = 1'b1;
        tick();
        resume = 1'b0;
        clear_cap();
        repeat (10) tick();
        n = 0;
        foreach (cap_code[i]) if (cap_code[i] == HLT_CLK && cap_st[i] == HALTED) n++;
        check1("halt_cycles", n, 10);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        clear_cap();
        tick();
        check1("resume_fetch", int'(cap_code[0]), int'(PC_to_MAR));

        // Undefined opcode
        ir_opcode = 8'hFF;
        clear_cap();
        repeat (4) tick();
        n = 0;
        foreach (cap_ill[i]) n += int'(cap_ill[i]);
        check1("undef_ill_count", n, 1);
        check1("undef_end", int'(cap_code[2]), int'(ENDMICRO));
        check1("undef_refetch", int'(cap_code[3]), int'(PC_to_MAR));

        // Runaway program: no ENDMICRO within 16 steps
        ir_opcode = 8'h09;
        clear_cap();
        repeat (19) tick();
        n = 0;
        foreach (cap_ill[i]) n += int'(cap_ill[i]);
        check1("overflow_ill_count", n, 1);
        check1("overflow_last_step", cap_step[17], 15);
        check1("overflow_fetch", int'(cap_code[18]), int'(PC_to_MAR));
        check1("overflow_ill_at_f0", int'(cap_ill[18]), 1);

        // Freeze with step_en low mid-EXEC
        ir_opcode = 8'h01;
        repeat (3) tick();
        step_en = 1'b0;
        clear_cap();
        repeat (3) tick();
        n = 0;
        foreach (cap_code[i])
            if (cap_code[i] == RAM_to_A && cap_step[i] == 1 && !cap_start[i] && !cap_ill[i]) n++;
        check1("freeze_held", n, 3);
        step_en = 1'b1;
        repeat (3) tick();

        // Asynchronous reset during WAIT_GPU
        ir_opcode = 8'h06;
        repeat (3) tick();
        gpu_busy = 1'b1;
        repeat (2) tick();
        check1("pre_reset_wait_gpu", int'(dec.current_microcode), int'(WAIT_GPU));
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        gpu_busy = 1'b0;

        // Randomized run
        repeat (3000) begin
            step_en = ($urandom_range(0, 9) != 0);
            resume = ($urandom_range(0, 3) == 0);
            ms_busy = ($urandom_range(0, 2) == 0);
            us_busy = ($urandom_range(0, 2) == 0);
            ftu_busy = ($urandom_range(0, 2) == 0);
            dd_busy = ($urandom_range(0, 2) == 0);
            gpu_busy = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) ir_opcode = 8'($urandom);
            else ir_opcode = 8'($urandom_range(0, 10));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
